// File: rtl/uart_cordic_sequencer.sv
// Frame-level controller between the UART byte link and the CORDIC core:
// parses angle requests, runs one CORDIC computation, returns sin/cos frames.
//
// state  | meaning
// IDLE   | hunting for request header
// ANG_HI | waiting for angle MSB
// ANG_LO | waiting for angle LSB
// START  | one-cycle CORDIC start pulse
// WAIT   | waiting for CORDIC done or timeout
// TX     | sending 5-byte response
// ERR_TX | sending single error byte
module uart_cordic_sequencer #(
  parameter int         RX_TIMEOUT_CYC = 100_000,
  parameter int         CORDIC_TMO_CYC = 1_024,
  parameter logic [7:0] HDR_REQ        = 8'hA5,
  parameter logic [7:0] HDR_RSP        = 8'h5A,
  parameter logic [7:0] ERR_RSP        = 8'hEE
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_err,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_cordic_start,
  output logic [15:0] o_cordic_angle,
  input  logic        i_cordic_done,
  input  logic [15:0] i_cordic_sin,
  input  logic [15:0] i_cordic_cos,
  output logic        o_busy,
  output logic [7:0]  o_err_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ANG_HI = 3'd1;
  localparam logic [2:0] S_ANG_LO = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_TX     = 3'd5;
  localparam logic [2:0] S_ERR_TX = 3'd6;

  // One down-counter serves both the byte-gap and CORDIC timeouts; they never overlap.
  localparam int TMR_MAX = (RX_TIMEOUT_CYC > CORDIC_TMO_CYC) ? RX_TIMEOUT_CYC : CORDIC_TMO_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(RX_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(CORDIC_TMO_CYC - 1);

  logic [2:0]       state, state_d;
  logic [TMR_W-1:0] tmr, tmr_d;
  logic [15:0]      angle_q, angle_d;
  logic [15:0]      sin_q, sin_d;
  logic [15:0]      cos_q, cos_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       err_cnt;
  logic             err_inc;
  logic [7:0]       tx_byte;

  always_comb begin
    state_d = state;
    tmr_d   = tmr;
    angle_d = angle_q;
    sin_d   = sin_q;
    cos_d   = cos_q;
    idx_d   = idx;
    err_inc = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_rx_err) begin
          err_inc = 1'b1;
        end else if (i_rx_valid && (i_rx_data == HDR_REQ)) begin
          state_d = S_ANG_HI;
          tmr_d   = GAP_LOAD;
        end
      end
      S_ANG_HI, S_ANG_LO: begin
        if (i_rx_err) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else if (i_rx_valid) begin
          tmr_d = GAP_LOAD;
          if (state == S_ANG_HI) begin
            angle_d[15:8] = i_rx_data;
            state_d       = S_ANG_LO;
          end else begin
            angle_d[7:0] = i_rx_data;
            state_d      = S_START;
          end
        end else if (tmr == '0) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr - 1'b1;
        end
      end
      S_START: begin
        tmr_d   = TMO_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the timeout cycle still wins.
        if (i_cordic_done) begin
          sin_d   = i_cordic_sin;
          cos_d   = i_cordic_cos;
          idx_d   = 3'd0;
          state_d = S_TX;
        end else if (tmr == '0) begin
          err_inc = 1'b1;
          state_d = S_ERR_TX;
        end else begin
          tmr_d = tmr - 1'b1;
        end
      end
      S_TX: begin
        if (i_tx_ready) begin
          if (idx == 3'd4) state_d = S_IDLE;
          else             idx_d   = idx + 3'd1;
        end
      end
      S_ERR_TX: begin
        if (i_tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // No frame buffering: any RX activity while the core or TX path is owned is an error.
    if (((state == S_START) || (state == S_WAIT) || (state == S_TX) || (state == S_ERR_TX)) &&
        (i_rx_valid || i_rx_err)) begin
      err_inc = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      tmr     <= '0;
      angle_q <= 16'h0000;
      sin_q   <= 16'h0000;
      cos_q   <= 16'h0000;
      idx     <= 3'd0;
      err_cnt <= 8'h00;
    end else begin
      state   <= state_d;
      tmr     <= tmr_d;
      angle_q <= angle_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
      idx     <= idx_d;
      if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    case (idx)
      3'd0:    tx_byte = HDR_RSP;
      3'd1:    tx_byte = sin_q[15:8];
      3'd2:    tx_byte = sin_q[7:0];
      3'd3:    tx_byte = cos_q[15:8];
      3'd4:    tx_byte = cos_q[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  // Outputs decode straight from state so reset clears them asynchronously.
  assign o_tx_data      = (state == S_TX) ? tx_byte : ((state == S_ERR_TX) ? ERR_RSP : 8'h00);
  assign o_tx_valid     = (state == S_TX) || (state == S_ERR_TX);
  assign o_cordic_start = (state == S_START);
  assign o_cordic_angle = angle_q;
  assign o_busy         = (state != S_IDLE);
  assign o_err_cnt      = err_cnt;

endmodule

// File: tb/tb_uart_cordic_sequencer.sv
// Directed self-checking bench for uart_cordic_sequencer with shortened timeouts.
module tb_uart_cordic_sequencer;

  localparam int RX_TMO = 60;
  localparam int CD_TMO = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_err = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        cordic_start;
  logic [15:0] cordic_angle;
  logic        cordic_done = 1'b0;
  logic [15:0] cordic_sin = 16'h0000;
  logic [15:0] cordic_cos = 16'h0000;
  logic        busy;
  logic [7:0]  err_cnt;

  uart_cordic_sequencer #(
    .RX_TIMEOUT_CYC(RX_TMO),
    .CORDIC_TMO_CYC(CD_TMO),
    .HDR_REQ(8'hA5),
    .HDR_RSP(8'h5A),
    .ERR_RSP(8'hEE)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .i_rx_err(rx_err),
    .o_tx_data(tx_data),
    .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready),
    .o_cordic_start(cordic_start),
    .o_cordic_angle(cordic_angle),
    .i_cordic_done(cordic_done),
    .i_cordic_sin(cordic_sin),
    .i_cordic_cos(cordic_cos),
    .o_busy(busy),
    .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  int         n_start = 0;
  int         stall_viol = 0;
  logic [7:0] txq[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Transfers and start pulses are recorded on the falling edge, half a cycle before they take effect.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!tx_valid || (tx_data != prev_data))) stall_viol++;
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (cordic_start) n_start++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_err();
    rx_err = 1'b1;
    step();
    rx_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    rx_valid    = 1'b0;
    rx_err      = 1'b0;
    cordic_done = 1'b0;
    steps(2);
    rst_n = 1'b1;
    step();
    txq.delete();
    n_start = 0;
  endtask

  task automatic pulse_done(input logic [15:0] s, input logic [15:0] c);
    cordic_sin  = s;
    cordic_cos  = c;
    cordic_done = 1'b1;
    step();
    cordic_done = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready high one cycle in three
  task automatic wait_idle(input string tag, input int max_cyc, input int mode);
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy) break;
      tx_ready = (mode == 0) ? 1'b1 : ((i % 3) == 2);
      step();
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_rsp(input string tag, input logic [15:0] s, input logic [15:0] c);
    logic [7:0] exp_b[5];
    exp_b[0] = 8'h5A;
    exp_b[1] = s[15:8];
    exp_b[2] = s[7:0];
    exp_b[3] = c[15:8];
    exp_b[4] = c[7:0];
    chk({tag, "_len"}, txq.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < txq.size()) chk($sformatf("%s_b%0d", tag, i), {24'd0, txq[i]}, {24'd0, exp_b[i]});
  endtask

  initial begin
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_txv", {31'd0, tx_valid}, 32'd0);
    chk("rst_txd", {24'd0, tx_data}, 32'd0);
    chk("rst_start", {31'd0, cordic_start}, 32'd0);
    chk("rst_angle", {16'd0, cordic_angle}, 32'd0);
    chk("rst_err", {24'd0, err_cnt}, 32'd0);
    do_reset();

    // 1: nominal frame, ready always high
    tx_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00);
    chk("t1_start", {31'd0, cordic_start}, 32'd1);
    chk("t1_angle", {16'd0, cordic_angle}, 32'h4000);
    step();
    chk("t1_start_once", {31'd0, cordic_start}, 32'd0);
    steps(19);
    pulse_done(16'h2D41, 16'h2D41);
    chk("t1_txv_first", {31'd0, tx_valid}, 32'd1);
    chk("t1_txd_first", {24'd0, tx_data}, 32'h5A);
    wait_idle("t1_idle", 20, 0);
    chk_rsp("t1", 16'h2D41, 16'h2D41);
    chk("t1_nstart", n_start, 32'd1);

    // 2: same frame, ready 1-of-3
    txq.delete();
    stall_viol = 0;
    tx_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00);
    steps(20);
    pulse_done(16'h2D41, 16'h2D41);
    wait_idle("t2_idle", 60, 1);
    chk_rsp("t2", 16'h2D41, 16'h2D41);
    chk("t2_stall", stall_viol, 32'd0);

    // 3: noise then aborted frame by byte gap, then good frame
    txq.delete();
    n_start = 0;
    tx_ready = 1'b1;
    send_byte(8'h00); send_byte(8'hFF);
    chk("t3_noise_idle", {31'd0, busy}, 32'd0);
    send_byte(8'hA5); send_byte(8'h12);
    steps(RX_TMO - 3);
    chk("t3_pre_tmo", {31'd0, busy}, 32'd1);
    steps(5);
    chk("t3_post_tmo", {31'd0, busy}, 32'd0);
    chk("t3_err", {24'd0, err_cnt}, 32'd1);
    chk("t3_nostart", n_start, 32'd0);
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
    chk("t3_angle", {16'd0, cordic_angle}, 32'h1234);
    chk("t3_start", {31'd0, cordic_start}, 32'd1);
    steps(3);
    pulse_done(16'h0123, 16'hFEDC);
    wait_idle("t3_idle", 20, 0);
    chk_rsp("t3", 16'h0123, 16'hFEDC);

    // 4: CORDIC timeout -> EE, held until accepted; stray done in IDLE ignored
    do_reset();
    pulse_done(16'h1111, 16'h2222);
    chk("t4_stray_done", {31'd0, busy}, 32'd0);
    tx_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    step();
    steps(CD_TMO - 3);
    chk("t4_pre_tmo", {31'd0, tx_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (tx_valid) break;
      step();
    end
    chk("t4_txv", {31'd0, tx_valid}, 32'd1);
    chk("t4_txd", {24'd0, tx_data}, 32'hEE);
    chk("t4_err", {24'd0, err_cnt}, 32'd1);
    steps(4);
    chk("t4_hold", {24'd0, tx_data}, 32'hEE);
    tx_ready = 1'b1;
    step();
    chk("t4_idle", {31'd0, busy}, 32'd0);
    chk("t4_len", txq.size(), 32'd1);
    if (txq.size() > 0) chk("t4_byte", {24'd0, txq[0]}, 32'hEE);

    // 5: byte during WAIT, rx_err in ANG_LO, collision, saturation
    do_reset();
    tx_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    step();
    send_byte(8'h77);
    chk("t5_wait_err", {24'd0, err_cnt}, 32'd1);
    pulse_done(16'h0A0B, 16'h0C0D);
    wait_idle("t5_idle", 20, 0);
    chk_rsp("t5", 16'h0A0B, 16'h0C0D);
    send_byte(8'hA5); send_byte(8'h01);
    send_err();
    chk("t5_anglo_err", {24'd0, err_cnt}, 32'd2);
    chk("t5_anglo_idle", {31'd0, busy}, 32'd0);
    rx_data = 8'hA5; rx_valid = 1'b1; rx_err = 1'b1;
    step();
    rx_valid = 1'b0; rx_err = 1'b0;
    chk("t5_coll_idle", {31'd0, busy}, 32'd0);
    chk("t5_coll_err", {24'd0, err_cnt}, 32'd3);
    for (int i = 0; i < 300; i++) send_err();
    chk("t5_sat", {24'd0, err_cnt}, 32'hFF);

    // 6: reset while stalled at idx 2
    do_reset();
    tx_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h55); send_byte(8'h66);
    steps(2);
    pulse_done(16'hABCD, 16'h1357);
    tx_ready = 1'b1;
    steps(2);
    tx_ready = 1'b0;
    chk("t6_idx2", {24'd0, tx_data}, 32'hCD);
    rst_n = 1'b0;
    #1;
    chk("t6_async_txv", {31'd0, tx_valid}, 32'd0);
    chk("t6_async_busy", {31'd0, busy}, 32'd0);
    chk("t6_async_err", {24'd0, err_cnt}, 32'd0);
    steps(2);
    rst_n = 1'b1;
    step();
    txq.delete();
    tx_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    chk("t6_angle", {16'd0, cordic_angle}, 32'h0000);
    chk("t6_start", {31'd0, cordic_start}, 32'd1);
    steps(5);
    pulse_done(16'h0000, 16'h7FFF);
    wait_idle("t6_idle", 20, 0);
    chk_rsp("t6", 16'h0000, 16'h7FFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
